br_pred: RTL
============

Name: br_pred

Overview:
- Fetch-stage branch predictor: direct-mapped BTB with per-entry 2-bit saturating counters.
- Produces the registered next-PC and the 76-bit prediction metadata bus that travels with each instruction down to the execute-stage branch resolver.
- Takes the resolver's outcome back as an update port.

Parameters:
- IDX_W, 6, BTB index width (2^IDX_W entries, indexed by pc[IDX_W+1:2]).
- TAG_W, 10, tag width, taken from pc[IDX_W+TAG_W+1:IDX_W+2].

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- lk_valid  in  1  fetch presents pc this cycle
- lk_stall  in  1  fetch stalled; hold outputs
- lk_pc  in  32  fetch PC
- pd_valid  out  1  prediction output valid
- pd_npc  out  32  predicted next PC
- pd_pre  out  76  prediction metadata bus
- up_valid  in  1  resolved branch/jump from execute
- up_pc  in  32  PC of resolved instruction
- up_taken  in  1  actual direction
- up_target  in  32  actual target
- up_cond  in  1  1 = conditional branch, 0 = unconditional jump
- up_idx  in  IDX_W  index echoed back from pd_pre

Behaviour:
- Reset (async, rstn=0):
  - all entry valid bits = 0; all counters = 2'b01 (weakly not-taken); targets/tags don't-care.
  - pd_valid = 0, pd_npc = 0, pd_pre = 0.
- Lookup, 1-cycle latency:
  - On a posedge with lk_valid=1 and lk_stall=0, read entry[idx(lk_pc)] and register the outputs:
    - hit = valid & tag match.
    - taken_pdc = hit & (~cond | ctr[1]).
    - pd_npc = taken_pdc ? target : lk_pc+4 (32-bit wrap).
    - pd_valid = 1.
- Stall and bubbles:
  - lk_stall=1: all pd_* hold their value (takes priority over lk_valid).
  - lk_valid=0 and lk_stall=0: pd_valid <= 0; pd_npc/pd_pre hold.
- pd_pre layout:
  - [31:0] predicted target (pd_npc).
  - [32] hit.
  - [33] iftaken_pdc = taken_pdc.
  - [34] ifnpc_pdc = hit (prediction drove npc).
  - [36:35] counter value read.
  - [37] cond bit of entry.
  - [38] iftwo = hit & counter saturated (2'b00 or 2'b11).
  - [38+IDX_W:39] index.
  - all remaining bits 0.
- Update (up_valid=1, applied at posedge, independent of lk_stall), entry = up_idx:
  - Hit (valid & tag(up_pc) match):
    - up_cond=1: counter +1 saturating at 11 if taken, -1 saturating at 00 if not taken.
    - target <= up_target when up_taken.
  - Miss and up_taken=1: allocate (overwrite).
    - valid=1, tag, target, cond set from the update.
    - counter = 2'b10 for conditional, 2'b11 for unconditional.
  - Miss and up_taken=0: no change.
  - The counter is never modified for unconditional entries (stays 11).
- Same-cycle lookup and update to the same index: the lookup reads the pre-update contents (read-before-write, no bypass). The update is visible to lookups on the following cycle.
- up_idx is authoritative for indexing; the tag check still uses up_pc.
- Reset asserted mid-operation: all state cleared immediately. The first lookup after deassertion misses.

Decomposition:
- Shared package holds:
  - PRE_W=76.
  - Field offsets: PRE_TGT_LSB, PRE_HIT, PRE_TAKEN=33, PRE_NPC=34, PRE_CTR_LSB=35, PRE_COND=37, PRE_TWO=38, PRE_IDX_LSB=39.
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
- One natural sub-module, br_pred_ctr2: a 2-bit saturating counter next-state function (ctr, taken -> ctr_next), reused by future predictor variants.

Test Plan:
1. Post-reset lookup pc=0x1C000000 -> next cycle pd_valid=1, pd_npc=0x1C000004, pd_pre[34:32]=000, pd_pre[38]=0.
2. Allocate conditional taken:
   - Update pc=0x1C000010, target=0x1C000100, cond=1, taken=1.
   - Then lookup 0x1C000010 -> pd_npc=0x1C000100, pd_pre[33]=1, pd_pre[34]=1, pd_pre[36:35]=10, pd_pre[38]=0.
3. Saturation: two more taken updates on that entry -> counter 11, pd_pre[38]=1. Three not-taken updates -> counter 00, pd_npc=pc+4, pd_pre[33]=0, pd_pre[38]=1.
4. Unconditional jump allocated at 0x1C000020 -> lookup gives counter 11 and taken. A not-taken update leaves the counter at 11.
5. Aliasing: entry held by 0x1C000010, lookup 0x1C010010 (same idx, different tag) -> hit=0, pd_npc=0x1C010014.
6. Timing and control:
   - Simultaneous lookup and allocating update to the same idx -> that lookup misses; the next lookup hits.
   - lk_stall=1 for 3 cycles -> pd_* unchanged.
   - rstn pulsed low asynchronously -> pd_valid=0 immediately and the previously hit pc misses.

Source files
------------

// File: rtl/br_pred_pkg.sv
// Shared definitions for the fetch-stage branch predictor family.
// Holds the prediction metadata bus width, its field offsets, the 2-bit
// counter encodings and a small helper that classifies counter states.
package br_pred_pkg;

  localparam int PRE_W       = 76;
  localparam int PRE_TGT_LSB = 0;
  localparam int PRE_HIT     = 32;
  localparam int PRE_TAKEN   = 33;
  localparam int PRE_NPC     = 34;
  localparam int PRE_CTR_LSB = 35;
  localparam int PRE_COND    = 37;
  localparam int PRE_TWO     = 38;
  localparam int PRE_IDX_LSB = 39;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // A counter at either end of its range gives a "strong" prediction.
  function automatic logic ctr_is_sat(input logic [1:0] c);
    return (c == CTR_SNT) || (c == CTR_ST);
  endfunction

endpackage

// File: rtl/br_pred_ctr2.sv
// 2-bit saturating counter next-state function.
// Ports:
//   ctr      - current counter value
//   taken    - observed direction (1 = count up, 0 = count down)
//   ctr_next - saturated next counter value
module br_pred_ctr2
  import br_pred_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/br_pred.sv
// Fetch-stage branch predictor: direct-mapped BTB with per-entry 2-bit
// saturating counters. Produces a registered next-PC plus a metadata bus
// that travels with the instruction to the execute-stage resolver, whose
// outcome comes back on the update port.
// Ports:
//   clk, rstn              - clock, asynchronous active-low reset
//   lk_valid/lk_stall/lk_pc - fetch lookup request, stall, PC
//   pd_valid/pd_npc/pd_pre - registered prediction outputs
//   up_*                   - resolved branch/jump from execute
module br_pred
  import br_pred_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             lk_valid,
  input  logic             lk_stall,
  input  logic [31:0]      lk_pc,
  output logic             pd_valid,
  output logic [31:0]      pd_npc,
  output logic [PRE_W-1:0] pd_pre,
  input  logic             up_valid,
  input  logic [31:0]      up_pc,
  input  logic             up_taken,
  input  logic [31:0]      up_target,
  input  logic             up_cond,
  input  logic [IDX_W-1:0] up_idx
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] cond_q, cond_d;
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [31:0]        tgt_d [ENTRIES];

  logic             pd_valid_q, pd_valid_d;
  logic [31:0]      pd_npc_q, pd_npc_d;
  logic [PRE_W-1:0] pd_pre_q, pd_pre_d;

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit, lk_taken, lk_cond;
  logic [1:0]       lk_ctr;
  logic [31:0]      lk_npc;
  logic [PRE_W-1:0] lk_pre;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[IDX_W+TAG_W+1:IDX_W+2];

  always_comb begin
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_ctr   = ctr_q[lk_idx];
    lk_cond  = cond_q[lk_idx];
    // Unconditional jumps are always taken once they are in the BTB.
    lk_taken = lk_hit && (!lk_cond || lk_ctr[1]);
    lk_npc   = lk_taken ? tgt_q[lk_idx] : lk_pc + 32'd4;
    lk_pre                          = '0;
    lk_pre[PRE_TGT_LSB +: 32]       = lk_npc;
    lk_pre[PRE_HIT]                 = lk_hit;
    lk_pre[PRE_TAKEN]               = lk_taken;
    lk_pre[PRE_NPC]                 = lk_hit;
    lk_pre[PRE_CTR_LSB +: 2]        = lk_ctr;
    lk_pre[PRE_COND]                = lk_cond;
    lk_pre[PRE_TWO]                 = lk_hit && ctr_is_sat(lk_ctr);
    lk_pre[PRE_IDX_LSB +: IDX_W]    = lk_idx;
  end

  // Stall holds everything; a bubble only drops valid.
  always_comb begin
    pd_valid_d = pd_valid_q;
    pd_npc_d   = pd_npc_q;
    pd_pre_d   = pd_pre_q;
    if (!lk_stall) begin
      pd_valid_d = lk_valid;
      if (lk_valid) begin
        pd_npc_d = lk_npc;
        pd_pre_d = lk_pre;
      end
    end
  end

  // ---------------- update ----------------
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       up_ctr_next;

  assign up_tag = up_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  br_pred_ctr2 u_ctr2 (
    .ctr      (ctr_q[up_idx]),
    .taken    (up_taken),
    .ctr_next (up_ctr_next)
  );

  always_comb begin
    valid_d = valid_q;
    cond_d  = cond_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (up_valid) begin
      if (up_hit) begin
        // Jump entries keep their counter pinned at strongly-taken.
        if (up_cond && cond_q[up_idx]) ctr_d[up_idx] = up_ctr_next;
        if (up_taken) tgt_d[up_idx] = up_target;
      end else if (up_taken) begin
        valid_d[up_idx] = 1'b1;
        cond_d[up_idx]  = up_cond;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = up_target;
        ctr_d[up_idx]   = up_cond ? CTR_WT : CTR_ST;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q    <= '0;
      cond_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
      pd_valid_q <= 1'b0;
      pd_npc_q   <= '0;
      pd_pre_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      cond_q     <= cond_d;
      ctr_q      <= ctr_d;
      pd_valid_q <= pd_valid_d;
      pd_npc_q   <= pd_npc_d;
      pd_pre_q   <= pd_pre_d;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  assign pd_valid = pd_valid_q;
  assign pd_npc   = pd_npc_q;
  assign pd_pre   = pd_pre_q;

  logic unused_up_pc;
  assign unused_up_pc = ^{up_pc[31:IDX_W+TAG_W+2], up_pc[IDX_W+1:0]};

endmodule
